// File: rtl/cache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared geometry and FSM encodings for the cache sequencing controller.
// Geometry constants give the default build (64 lines of 4 bytes, 32-bit
// addresses). The module parameters default to these values.
// ---------------------------------------------------------------------------
package cache_ctrl_pkg;

  localparam int OFFSET_LENGTH  = 2;
  localparam int INDEX_LENGTH   = 6;
  localparam int CACHE_LINE_NUM = 1 << INDEX_LENGTH;
  localparam int TAG_LENGTH     = 32 - INDEX_LENGTH - OFFSET_LENGTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RMISS  = 3'd1,
    ST_REFILL = 3'd2,
    ST_WTHRU  = 3'd3,
    ST_FLUSH  = 3'd4
  } state_e;

endpackage

// File: rtl/cache_flush_sweeper.sv
// ---------------------------------------------------------------------------
// cache_flush_sweeper
// Index counter for the invalidate-all sweep. Advances one index per enabled
// cycle and flags the last index so the controller can finish the sweep.
// Ports:
//   clk, rst     clock, synchronous active-high reset (counter -> 0)
//   en           sweep in progress this cycle
//   index        index being invalidated this cycle
//   done         high on the cycle the last index is invalidated
// ---------------------------------------------------------------------------
module cache_flush_sweeper
  import cache_ctrl_pkg::*;
#(
  parameter int INDEX_W = INDEX_LENGTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [INDEX_W-1:0] index,
  output logic               done
);

  localparam logic [INDEX_W-1:0] LAST_IDX = '1;

  logic [INDEX_W-1:0] r_count;

  // Natural wrap of the increment returns the counter to 0 after the last line.
  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (en)
      r_count <= r_count + INDEX_W'(1);
  end

  assign index = r_count;
  assign done  = en & (r_count == LAST_IDX);

endmodule

// File: rtl/cache_ctrl.sv
// ---------------------------------------------------------------------------
// cache_ctrl
// Sequencing FSM for a direct-mapped, write-through, no-write-allocate cache.
// Drives valid/tag/data RAM controls, stalls the core on misses, runs the
// memory handshake for refills and write-throughs, and sweeps all valid bits
// clear on a flush request.
// Optional: define CACHE_PERF_CNT_EN to add saturating read hit/miss counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   core_req/we/addr         core access (held until !core_stall)
//   core_stall               core must hold its request
//   flush_req, flush_done    invalidate-all request / end-of-sweep pulse
//   valid_rd, tag_match      RAM lookups at ram_index
//   ram_index                index to valid/tag/data RAMs
//   valid_w_en, valid_in     valid RAM write port
//   tag_w_en                 tag RAM write enable
//   data_w_en, data_from_mem data RAM write enable and source select
//   mem_req/we/addr, mem_ready  external memory handshake
//   hit_cnt, miss_cnt        (CACHE_PERF_CNT_EN only) read hit/miss counts
// ---------------------------------------------------------------------------
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = INDEX_LENGTH,
  parameter int OFFSET_W = OFFSET_LENGTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               core_req,
  input  logic               core_we,
  input  logic [ADDR_W-1:0]  core_addr,
  output logic               core_stall,
  input  logic               flush_req,
  output logic               flush_done,
  input  logic               valid_rd,
  input  logic               tag_match,
  output logic [INDEX_W-1:0] ram_index,
  output logic               valid_w_en,
  output logic               valid_in,
  output logic               tag_w_en,
  output logic               data_w_en,
  output logic               data_from_mem,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                w_latch;
  logic                w_hit;
  logic                w_sweep_en;
  logic                w_sweep_done;
  logic [INDEX_W-1:0]  w_sweep_idx;
  logic [INDEX_W-1:0]  w_core_idx;
  logic [INDEX_W-1:0]  w_lat_idx;

  assign w_hit      = valid_rd & tag_match;
  assign w_core_idx = core_addr[OFFSET_W +: INDEX_W];
  assign w_lat_idx  = r_addr[OFFSET_W +: INDEX_W];

  cache_flush_sweeper #(.INDEX_W(INDEX_W)) u_sweeper (
    .clk   (clk),
    .rst   (rst),
    .en    (w_sweep_en),
    .index (w_sweep_idx),
    .done  (w_sweep_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch)
        r_addr <= core_addr;
    end
  end

  // All outputs are held at 0 while rst is asserted, so an aborted refill or
  // sweep stops driving RAMs and memory in the reset cycle itself.
  always_comb begin
    w_state_nxt   = r_state;
    w_latch       = 1'b0;
    w_sweep_en    = 1'b0;
    core_stall    = 1'b0;
    flush_done    = 1'b0;
    ram_index     = '0;
    valid_w_en    = 1'b0;
    valid_in      = 1'b0;
    tag_w_en      = 1'b0;
    data_w_en     = 1'b0;
    data_from_mem = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    if (rst) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          ram_index = w_core_idx;
          if (flush_req) begin
            core_stall  = 1'b1;
            w_state_nxt = ST_FLUSH;
          end else if (core_req) begin
            if (!core_we) begin
              if (!w_hit) begin
                core_stall  = 1'b1;
                w_latch     = 1'b1;
                w_state_nxt = ST_RMISS;
              end
            end else begin
              // Write-through: update the line only if present, never allocate.
              data_w_en   = w_hit;
              core_stall  = 1'b1;
              w_latch     = 1'b1;
              w_state_nxt = ST_WTHRU;
            end
          end
        end
        ST_RMISS: begin
          ram_index   = w_lat_idx;
          core_stall  = 1'b1;
          mem_req     = 1'b1;
          mem_addr    = {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          if (mem_ready)
            w_state_nxt = ST_REFILL;
        end
        ST_REFILL: begin
          ram_index     = w_lat_idx;
          core_stall    = 1'b1;
          valid_w_en    = 1'b1;
          valid_in      = 1'b1;
          tag_w_en      = 1'b1;
          data_w_en     = 1'b1;
          data_from_mem = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
        ST_WTHRU: begin
          ram_index  = w_lat_idx;
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = r_addr;
          core_stall = !mem_ready;
          if (mem_ready)
            w_state_nxt = ST_IDLE;
        end
        ST_FLUSH: begin
          w_sweep_en = 1'b1;
          ram_index  = w_sweep_idx;
          core_stall = 1'b1;
          valid_w_en = 1'b1;
          flush_done = w_sweep_done;
          if (w_sweep_done)
            w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_flush_start;
  logic        w_eval_rd;

  assign w_flush_start = (r_state == ST_IDLE) & flush_req;
  assign w_eval_rd     = (r_state == ST_IDLE) & !flush_req & core_req & !core_we;

  always_ff @(posedge clk) begin
    if (rst || w_flush_start) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_eval_rd) begin
      if (w_hit)
        r_hit_cnt  <= sat_inc(r_hit_cnt);
      else
        r_miss_cnt <= sat_inc(r_miss_cnt);
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl
// Directed bench for cache_ctrl: a vector table of single-cycle IDLE
// decisions, then hand-written sequences for refill, write-through, flush
// sweep, reset aborts and (when CACHE_PERF_CNT_EN is defined) the counters.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr;
  logic        core_stall;
  logic        flush_req, flush_done;
  logic        valid_rd, tag_match;
  logic [5:0]  ram_index;
  logic        valid_w_en, valid_in, tag_w_en, data_w_en, data_from_mem;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic        mem_ready;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_stall(core_stall),
    .flush_req(flush_req), .flush_done(flush_done),
    .valid_rd(valid_rd), .tag_match(tag_match),
    .ram_index(ram_index),
    .valid_w_en(valid_w_en), .valid_in(valid_in), .tag_w_en(tag_w_en),
    .data_w_en(data_w_en), .data_from_mem(data_from_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ready(mem_ready)
`ifdef CACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic        flush;
    logic        vld;
    logic        tm;
    logic        exp_stall;
    logic        exp_dwe;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t vecs[8];

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    core_req  = 1'b0;
    core_we   = 1'b0;
    core_addr = 32'h0;
    flush_req = 1'b0;
    valid_rd  = 1'b0;
    tag_match = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic vld, input logic tm);
    core_req  = req;
    core_we   = we;
    core_addr = addr;
    valid_rd  = vld;
    tag_match = tm;
  endtask

  initial begin
    int  seen;
    //                name         req   we    addr          flush vld   tm    stall dwe   idx
    vecs[0] = '{"rd_hit",      1'b1, 1'b0, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h11};
    vecs[1] = '{"rd_miss_inv", 1'b1, 1'b0, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h10};
    vecs[2] = '{"rd_miss_tag", 1'b1, 1'b0, 32'h0000_00FC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h3F};
    vecs[3] = '{"wr_hit",      1'b1, 1'b1, 32'h0000_0084, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h21};
    vecs[4] = '{"wr_miss",     1'b1, 1'b1, 32'h0000_0088, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h22};
    vecs[5] = '{"flush_rd",    1'b1, 1'b0, 32'h0000_0044, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h11};
    vecs[6] = '{"flush_wr",    1'b1, 1'b1, 32'h0000_0084, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'h21};
    vecs[7] = '{"no_req",      1'b0, 1'b0, 32'h0000_100C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h03};

    // Reset: outputs held at 0 even with a pending read miss on the inputs.
    clear_inputs();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h40, 1'b0, 1'b0);
    step();
    step();
    chk1("rst_stall", core_stall, 1'b0);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_ram_index", 32'(ram_index), 32'h0);
    do_reset();
    step();
    chk1("post_rst_stall", core_stall, 1'b0);
    chk1("post_rst_mem_req", mem_req, 1'b0);

    // Single-cycle IDLE decisions.
    for (int k = 0; k < 8; k++) begin
      drive(vecs[k].req, vecs[k].we, vecs[k].addr, vecs[k].vld, vecs[k].tm);
      flush_req = vecs[k].flush;
      #1;
      chk1({vecs[k].name, "_stall"}, core_stall, vecs[k].exp_stall);
      chk1({vecs[k].name, "_dwe"}, data_w_en, vecs[k].exp_dwe);
      chk1({vecs[k].name, "_dfm"}, data_from_mem, 1'b0);
      chk32({vecs[k].name, "_idx"}, 32'(ram_index), 32'(vecs[k].exp_idx));
      chk32({vecs[k].name, "_oth"}, {29'b0, valid_w_en, tag_w_en, mem_req}, 32'h0);
      step();
      do_reset();
      step();
    end

    // Read miss refill, memory ready on the third RMISS cycle.
    drive(1'b1, 1'b0, 32'h0000_0043, 1'b0, 1'b0);
    #1;
    chk1("miss_stall", core_stall, 1'b1);
    core_addr = 32'h0000_0043;
    step();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        mem_ready = 1'b1;
        #1;
      end
      chk1("rmiss_req", mem_req, 1'b1);
      chk1("rmiss_we", mem_we, 1'b0);
      chk32("rmiss_addr", mem_addr, 32'h0000_0040);
      chk1("rmiss_stall", core_stall, 1'b1);
      chk32("rmiss_idx", 32'(ram_index), 32'h10);
      if (c < 2) step();
    end
    step();
    mem_ready = 1'b0;
    #1;
    chk32("refill_en", {27'b0, valid_w_en, valid_in, tag_w_en, data_w_en, data_from_mem}, 32'h1F);
    chk1("refill_stall", core_stall, 1'b1);
    chk1("refill_mem_req", mem_req, 1'b0);
    valid_rd  = 1'b1;
    tag_match = 1'b1;
    step();
    chk1("replay_stall", core_stall, 1'b0);
    chk32("replay_en", {28'b0, valid_w_en, tag_w_en, data_w_en, mem_req}, 32'h0);
    // Spurious mem_ready in IDLE is ignored.
    clear_inputs();
    mem_ready = 1'b1;
    step();
    chk1("spur_ready_mem_req", mem_req, 1'b0);
    chk1("spur_ready_stall", core_stall, 1'b0);
    mem_ready = 1'b0;
    step();

    // Write hit: data RAM written in IDLE, then write-through.
    drive(1'b1, 1'b1, 32'h0000_0084, 1'b1, 1'b1);
    #1;
    chk1("wh_dwe", data_w_en, 1'b1);
    chk1("wh_stall", core_stall, 1'b1);
    step();
    chk1("wh_mem_req", mem_req, 1'b1);
    chk1("wh_mem_we", mem_we, 1'b1);
    chk32("wh_mem_addr", mem_addr, 32'h0000_0084);
    chk1("wh_wt_dwe", data_w_en, 1'b0);
    chk1("wh_wt_stall", core_stall, 1'b1);
    step();
    chk1("wh_wait_req", mem_req, 1'b1);
    mem_ready = 1'b1;
    #1;
    chk1("wh_release", core_stall, 1'b0);
    step();
    clear_inputs();
    #1;
    chk1("wh_done_req", mem_req, 1'b0);

    // Write miss: never touches the data RAM.
    drive(1'b1, 1'b1, 32'h0000_0088, 1'b0, 1'b0);
    #1;
    chk1("wm_dwe", data_w_en, 1'b0);
    chk1("wm_stall", core_stall, 1'b1);
    step();
    mem_ready = 1'b1;
    #1;
    chk32("wm_mem_addr", mem_addr, 32'h0000_0088);
    chk1("wm_mem_we", mem_we, 1'b1);
    chk1("wm_wt_dwe", data_w_en, 1'b0);
    chk1("wm_release", core_stall, 1'b0);
    step();
    clear_inputs();
    #1;
    chk1("wm_done_req", mem_req, 1'b0);

    // Flush and read in the same cycle: flush wins, 64-cycle sweep, then read.
    drive(1'b1, 1'b0, 32'h0000_0044, 1'b1, 1'b1);
    flush_req = 1'b1;
    #1;
    chk1("fl_start_stall", core_stall, 1'b1);
    for (int i = 0; i < 64; i++) begin
      step();
      if (i == 2) flush_req = 1'b0;
      chk32("fl_idx", 32'(ram_index), 32'(i));
      chk1("fl_vwe", valid_w_en, 1'b1);
      chk1("fl_vin", valid_in, 1'b0);
      chk1("fl_stall", core_stall, 1'b1);
      chk1("fl_done", flush_done, (i == 63));
    end
    step();
    chk1("fl_after_stall", core_stall, 1'b0);
    chk1("fl_after_done", flush_done, 1'b0);
    chk1("fl_after_vwe", valid_w_en, 1'b0);
    clear_inputs();
    step();

    // Reset during RMISS drops mem_req on the next edge.
    drive(1'b1, 1'b0, 32'h0000_0040, 1'b0, 1'b0);
    step();
    chk1("rr_mem_req", mem_req, 1'b1);
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk1("rr_after_req", mem_req, 1'b0);
    chk1("rr_after_stall", core_stall, 1'b0);
    step();
    chk1("rr_idle_req", mem_req, 1'b0);

    // Reset mid-FLUSH: the next sweep restarts at index 0.
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk32("rf_mid_idx", 32'(ram_index), 32'd10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk1("rf_idle_vwe", valid_w_en, 1'b0);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk32("rf_restart_idx", 32'(ram_index), 32'd0);
    chk1("rf_restart_vwe", valid_w_en, 1'b1);
    seen = 0;
    for (int i = 0; i < 70 && seen == 0; i++) begin
      if (flush_done) seen = i + 1;
      else step();
    end
    chk32("rf_sweep_len", 32'(seen), 32'd64);
    step();

`ifdef CACHE_PERF_CNT_EN
    do_reset();
    step();
    chk32("pc_rst_hit", hit_cnt, 32'd0);
    chk32("pc_rst_miss", miss_cnt, 32'd0);
    drive(1'b1, 1'b0, 32'h0000_0010, 1'b1, 1'b1);
    step();
    clear_inputs();
    for (int m = 0; m < 2; m++) begin
      drive(1'b1, 1'b0, 32'h0000_0020 + 32'(m * 4), 1'b0, 1'b0);
      step();
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      valid_rd  = 1'b1;
      tag_match = 1'b1;
      step();
      step();
      clear_inputs();
    end
    chk32("pc_hit", hit_cnt, 32'd3);
    chk32("pc_miss", miss_cnt, 32'd2);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk32("pc_fl_hit", hit_cnt, 32'd0);
    chk32("pc_fl_miss", miss_cnt, 32'd0);
    for (int i = 0; i < 70; i++) step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Per-cache sequencing FSM for a direct-mapped, write-through, no-write-allocate cache.
- Drives the valid-bit RAM, tag RAM and data RAM write enables and index, and stalls the core on misses.
- Runs the external memory handshake for refills and write-throughs.
- Provides a full-cache invalidate sweep that clears every valid bit one index per cycle.

Parameters:
- ADDR_W, 32, core/memory byte address width.
- INDEX_W, 6, cache index width; line count = 2**INDEX_W.
- OFFSET_W, 2, byte-offset bits; tag width = ADDR_W-INDEX_W-OFFSET_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- core_req  in  1  core access request, held until !core_stall
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  access address
- core_stall  out  1  core must hold request
- flush_req  in  1  invalidate-all request pulse
- flush_done  out  1  one-cycle pulse at sweep end
- valid_rd  in  1  valid bit at current index
- tag_match  in  1  tag RAM compare result at current index
- ram_index  out  INDEX_W  index to valid/tag/data RAMs
- valid_w_en  out  1  valid RAM write enable
- valid_in  out  1  valid bit to write
- tag_w_en  out  1  tag RAM write enable
- data_w_en  out  1  data RAM write enable
- data_from_mem  out  1  data RAM source: 1 = mem_rdata, 0 = core wdata
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address (line-aligned on reads)
- mem_ready  in  1  memory completion, single cycle

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst): on rst, state=IDLE, sweep counter=0, latched address=0, and all outputs are 0. Reset mid-refill or mid-sweep aborts immediately, and mem_req drops on the next edge. Valid RAM contents are cleared by the RAM's own reset, not by this block.
- hit = valid_rd & tag_match. Both are combinational from ram_index; ram_index = core_addr index field in IDLE, otherwise the latched or sweep index.
- IDLE:
  - flush_req has priority over core_req in the same cycle: go to FLUSH, core_stall=1.
  - Read hit: 0 wait cycles, core_stall=0, stay IDLE.
  - Read miss: latch address, core_stall=1, go to RMISS.
  - Write hit: data_w_en=1, data_from_mem=0 this cycle, latch address, core_stall=1, go to WTHRU.
  - Write miss: no RAM writes, latch address, core_stall=1, go to WTHRU.
- RMISS:
  - mem_req=1, mem_we=0, mem_addr = latched address with offset zeroed; core_stall=1.
  - On mem_ready go to REFILL.
- REFILL (1 cycle):
  - valid_w_en=1, valid_in=1, tag_w_en=1, data_w_en=1, data_from_mem=1; core_stall=1.
  - Return to IDLE. The replayed access then hits: refill read latency = memory latency + 2.
- WTHRU:
  - mem_req=1, mem_we=1, mem_addr = latched address; core_stall=1.
  - On mem_ready, core_stall=0 in the same cycle and go to IDLE.
- FLUSH:
  - Each cycle valid_w_en=1, valid_in=0, ram_index=counter, counter++; core_stall=1.
  - At counter = 2**INDEX_W-1: flush_done=1, counter wraps to 0, go to IDLE. Sweep length is exactly 2**INDEX_W cycles.
  - flush_req during FLUSH/RMISS/REFILL/WTHRU is ignored, not queued.
- mem_req never drops before mem_ready. mem_ready while mem_req=0 is ignored.
- No write enable is asserted in IDLE except data_w_en on a write hit.

Optional Feature:
- Macro CACHE_PERF_CNT_EN.
- When defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0]. They count accepted read hits and read misses (evaluated in IDLE), saturate at 0xFFFFFFFF, and are cleared by rst and by flush start.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared defines header: INDEX_LENGTH, CACHE_LINE_NUM, TAG_LENGTH, OFFSET_LENGTH, plus FSM state encodings (IDLE=0, RMISS=1, REFILL=2, WTHRU=3, FLUSH=4) as a 3-bit localparam set.
- One natural sub-module: cache_flush_sweeper (index counter + done pulse), instantiated by cache_ctrl.

Test Plan:
- Reset, then read 0x0000_0040 with valid_rd=0 -> RMISS, mem_req=1, mem_addr=0x40; mem_ready after 3 cycles -> REFILL with valid_w_en=tag_w_en=data_w_en=1, then hit, core_stall=0.
- Read hit (valid_rd=1, tag_match=1) -> core_stall=0 same cycle, no mem_req, no write enables.
- Write hit to 0x84 -> data_w_en=1 in the IDLE cycle, then mem_req=mem_we=1, mem_addr=0x84, core_stall released on mem_ready. Write miss -> same, but data_w_en never asserted.
- flush_req and core_req in the same cycle with INDEX_W=6 -> 64 cycles of valid_w_en=1, valid_in=0, ram_index 0..63, flush_done on the 64th cycle, then the core request is serviced.
- rst asserted during RMISS with mem_req high -> next edge: mem_req=0, state IDLE, core_stall=0. rst in mid-FLUSH -> counter=0.
- With CACHE_PERF_CNT_EN: 3 read hits + 2 read misses -> hit_cnt=3, miss_cnt=2; flush -> both 0.
